// File: rtl/booth_acc_pkg.sv
// Shared types, default widths and saturation limits for the Booth product accumulator.
// Saturation limits are only consumed when BOOTH_ACC_SATURATE_EN is defined.
package booth_acc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   localparam int unsigned PROD_W_DEF = 32;
   localparam int unsigned ACC_W_DEF  = 40;
   localparam int unsigned CNT_W_DEF  = 8;

   // Limits are returned in 64 bits; callers narrow them to their own ACC_W.
   function automatic logic [63:0] sat_max(input int unsigned acc_w);
      return (64'd1 << (acc_w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int unsigned acc_w);
      return 64'd1 << (acc_w - 1);
   endfunction

endpackage

// File: rtl/booth_acc_addsat.sv
// Combinational ACC_W signed adder with overflow flag.
// With BOOTH_ACC_SATURATE_EN defined, an overflowing sum clamps to the signed limit.
module booth_acc_addsat
   import booth_acc_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

`ifdef BOOTH_ACC_SATURATE_EN
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
   localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));
`endif

   logic [ACC_W-1:0] raw;

   always_comb begin
      raw = a + b;
      ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef BOOTH_ACC_SATURATE_EN
      if (ovf) begin
         sum = b[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
         sum = raw;
      end
`else
      sum = raw;
`endif
   end

endmodule

// File: rtl/booth_prod_accumulator.sv
// Accumulates programmable-length blocks of signed Booth products and hands the sum out on valid/ready.
// BOOTH_ACC_SATURATE_EN selects clamping instead of wrap on signed overflow.
module booth_prod_accumulator
   import booth_acc_pkg::*;
#(
   parameter int unsigned PROD_W = PROD_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              power_saved_in,
   output logic              prod_ready,
   input  logic [CNT_W-1:0]  acc_len,
   input  logic              acc_clear,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [ACC_W-1:0]  result,
   output logic              overflow,
   output logic              busy
);

   localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, result_q, operand, add_sum, acc_step;
   logic [CNT_W:0]   cnt_q, len_q, len_eff, cnt_inc;
   logic             ovf_q, add_ovf, beat, acc_en, hold_clamp;

   assign operand = power_saved_in ? '0 : {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
   assign beat    = prod_valid && prod_ready;
   // Length 0 encodes 2^CNT_W, hence the extra counter bit.
   assign len_eff = (acc_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, acc_len};
   assign cnt_inc = cnt_q + CNT_ONE;

`ifdef BOOTH_ACC_SATURATE_EN
   assign hold_clamp = ovf_q;
`else
   assign hold_clamp = 1'b0;
`endif

   assign acc_en   = !power_saved_in && !hold_clamp;
   assign acc_step = acc_en ? add_sum : acc_q;

   booth_acc_addsat #(
      .ACC_W(ACC_W)
   ) u_addsat (
      .a  (acc_q),
      .b  (operand),
      .sum(add_sum),
      .ovf(add_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      prod_ready   = (state_q != DONE);
      result_valid = (state_q == DONE);
      busy         = (state_q != IDLE);
      case (state_q)
         IDLE:    if (beat) state_d = (len_eff == CNT_ONE) ? DONE : ACCUM;
         ACCUM:   if (beat && (cnt_inc == len_q)) state_d = DONE;
         DONE:    if (result_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (acc_clear) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         len_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else if (acc_clear) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (beat) begin
               len_q <= len_eff;
               acc_q <= operand;
               cnt_q <= CNT_ONE;
               ovf_q <= 1'b0;
               if (len_eff == CNT_ONE) result_q <= operand;
            end
            ACCUM: if (beat) begin
               cnt_q <= cnt_inc;
               acc_q <= acc_step;
               ovf_q <= ovf_q | (acc_en & add_ovf);
               if (cnt_inc == len_q) result_q <= acc_step;
            end
            DONE: if (result_ready) begin
               acc_q <= '0;
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign result   = result_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_booth_prod_accumulator.sv
// Bench for booth_prod_accumulator: directed literal cases, randomized traffic against a
// transaction-level model, and a 36-bit instance exercising signed overflow.
module tb_booth_prod_accumulator;

   localparam int W = 40;
`ifdef BOOTH_ACC_SATURATE_EN
   localparam bit TB_SAT = 1'b1;
   localparam longint OVF36_EXP = 64'sd34359738367;
`else
   localparam bit TB_SAT = 1'b0;
   localparam longint OVF36_EXP = 64'sd35431317537 - 64'sd68719476736;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        prod_valid = 0, power_saved_in = 0, acc_clear = 0, result_ready = 1;
   logic [31:0] prod_in = '0;
   logic [7:0]  acc_len = 8'd1;
   logic        prod_ready, result_valid, overflow, busy;
   logic [39:0] result;

   logic        v36 = 0, ps36 = 0, clr36 = 0, rdy36 = 0;
   logic [31:0] p36 = '0;
   logic [7:0]  len36 = 8'd33;
   logic        prod_ready36, rv36, ovf36, busy36;
   logic [35:0] res36;

   booth_prod_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_in(prod_in),
      .power_saved_in(power_saved_in), .prod_ready(prod_ready), .acc_len(acc_len),
      .acc_clear(acc_clear), .result_valid(result_valid), .result_ready(result_ready),
      .result(result), .overflow(overflow), .busy(busy)
   );

   booth_prod_accumulator #(.PROD_W(32), .ACC_W(36), .CNT_W(8)) dut36 (
      .clk(clk), .rst_n(rst_n), .prod_valid(v36), .prod_in(p36),
      .power_saved_in(ps36), .prod_ready(prod_ready36), .acc_len(len36),
      .acc_clear(clr36), .result_valid(rv36), .result_ready(rdy36),
      .result(res36), .overflow(ovf36), .busy(busy36)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model (transaction level) ----------------
   function automatic longint wrapw(input longint v, input int w);
      longint m;
      m = longint'(1) <<< w;
      v = v & (m - 1);
      if (v >= (m >>> 1)) v = v - m;
      return v;
   endfunction

   function automatic longint acc_add(input longint s, input longint op, input int w,
                                      input bit ovf_in, output bit ovf_out);
      longint lmax, lmin, t;
      lmax = (longint'(1) <<< (w - 1)) - 1;
      lmin = -lmax - 1;
      ovf_out = ovf_in;
      if (TB_SAT && ovf_in) return s;
      t = s + op;
      if (t > lmax || t < lmin) begin
         ovf_out = 1'b1;
         if (TB_SAT) return (t > lmax) ? lmax : lmin;
         return wrapw(t, w);
      end
      return t;
   endfunction

   bit     m_in, m_pend, m_ovf, m_res_ovf;
   int     m_cnt, m_len;
   longint m_sum, m_res;

   always @(posedge clk or negedge rst_n) begin
      longint s, op;
      int c, l;
      bit ov;
      if (!rst_n) begin
         m_in <= 0; m_pend <= 0; m_sum <= 0; m_cnt <= 0; m_len <= 0;
         m_ovf <= 0; m_res <= 0; m_res_ovf <= 0;
      end else if (acc_clear) begin
         m_in <= 0; m_pend <= 0; m_sum <= 0; m_cnt <= 0; m_ovf <= 0; m_res <= 0; m_res_ovf <= 0;
      end else if (m_pend) begin
         if (result_ready) m_pend <= 0;
      end else if (prod_valid) begin
         op = power_saved_in ? 64'sd0 : longint'($signed(prod_in));
         if (!m_in) begin
            l = (acc_len == 0) ? 256 : int'(acc_len);
            c = 1; s = op; ov = 0;
         end else begin
            l = m_len;
            c = m_cnt + 1;
            s = acc_add(m_sum, op, W, m_ovf, ov);
         end
         m_len <= l; m_cnt <= c; m_sum <= s; m_ovf <= ov;
         if (c == l) begin
            m_pend <= 1; m_in <= 0; m_res <= s; m_res_ovf <= ov;
         end else begin
            m_in <= 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("prod_ready", prod_ready, !m_pend);
         chk("result_valid", result_valid, m_pend);
         chk("busy", busy, m_in || m_pend);
         if (m_pend) begin
            chk("result", $signed(result), m_res);
            chk("overflow", overflow, m_res_ovf);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic [31:0] p, input bit ps);
      int n = 0;
      prod_valid = 1; prod_in = p; power_saved_in = ps;
      while (!prod_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("beat_timeout", 1, 0);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_res(input string n, input longint v, input bit ov);
      chk({n, "_valid"}, result_valid, 1);
      chk({n, "_dut"}, $signed(result), v);
      chk({n, "_model"}, m_res, v);
      chk({n, "_ovf"}, overflow, ov);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1;
      chk("rst_prod_ready", prod_ready, 1);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_result", $signed(result), 0);

      acc_len = 8'd1;
      beat(32'd7006652, 0); prod_valid = 0;
      expect_res("single", 7006652, 0);
      @(negedge clk);

      acc_len = 8'd3;
      beat(32'd2468642, 0); beat(32'd14811852, 0); beat(32'd37029630, 0); prod_valid = 0;
      expect_res("three", 54310124, 0);
      chk("three_done_ready", prod_ready, 0);
      @(negedge clk);
      chk("three_after_ready", prod_ready, 1);
      chk("three_after_valid", result_valid, 0);

      acc_len = 8'd2;
      beat(-32'sd14811852, 0); beat(32'sd7405926, 0); prod_valid = 0;
      expect_res("signed", -7405926, 0);
      @(negedge clk);

      acc_len = 8'd4;
      beat(32'd7006652, 0); beat(32'h12345678, 1); beat(32'd100, 0); beat(-32'sd100, 0);
      prod_valid = 0;
      expect_res("psave", 7006652, 0);
      @(negedge clk);

      result_ready = 0;
      acc_len = 8'd2;
      beat(32'd1000, 0); beat(32'd234, 0);
      prod_valid = 1; prod_in = 32'd999; acc_len = 8'd4;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", result_valid, 1);
         chk("bp_result", $signed(result), 1234);
         chk("bp_ready", prod_ready, 0);
         @(negedge clk);
      end
      result_ready = 1;
      beat(32'd999, 0);
      beat(32'd1, 0);
      prod_valid = 1; prod_in = 32'd555; acc_clear = 1;
      @(negedge clk);
      acc_clear = 0; prod_valid = 0;
      chk("clr_busy", busy, 0);
      chk("clr_valid", result_valid, 0);
      acc_len = 8'd2;
      beat(32'd5, 0); beat(32'd6, 0); prod_valid = 0;
      expect_res("after_clr", 11, 0);
      @(negedge clk);

      acc_len = 8'd5;
      beat(32'd10, 0); beat(32'd20, 0); prod_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_ready", prod_ready, 1);
      chk("arst_valid", result_valid, 0);
      @(negedge clk);
      rst_n = 1;
      acc_len = 8'd1;
      beat(32'd42, 0); prod_valid = 0;
      expect_res("post_arst", 42, 0);
      @(negedge clk);

      for (int i = 0; i < 4000; i++) begin
         prod_valid     = ($urandom % 4) != 0;
         prod_in        = $urandom;
         power_saved_in = ($urandom % 10) == 0;
         acc_len        = (($urandom % 16) == 0) ? 8'd0 : 8'(1 + $urandom % 6);
         result_ready   = ($urandom % 3) != 0;
         acc_clear      = ($urandom % 200) == 0;
         @(negedge clk);
      end
      prod_valid = 0; acc_clear = 1; result_ready = 1; power_saved_in = 0;
      @(negedge clk);
      acc_clear = 0;
      @(negedge clk);

      v36 = 1; p36 = 32'd1073676289;
      repeat (33) @(negedge clk);
      v36 = 0;
      chk("ovf36_valid", rv36, 1);
      chk("ovf36_result", $signed(res36), OVF36_EXP);
      chk("ovf36_flag", ovf36, 1);
      chk("ovf36_ready", prod_ready36, 0);
      rdy36 = 1;
      @(negedge clk);
      chk("ovf36_release", rv36, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
